// File: rtl/hdc_sched_pkg.sv
`default_nettype none
// =============================================================================
// Module      : hdc_sched_pkg
// Description : Shared types and constants for the HDC fusion scheduler.
// Revision    : 1.0 - initial release
// =============================================================================

// Channel geometry normally arrives from const.vh; fall back to a 4x8 window.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

package hdc_sched_pkg;
    localparam int NUM_REQ_DEF         = 4;
    localparam int MAX_OUTSTANDING_DEF = 8;
    localparam int FEAT_WIDTH_DEF      = `TOTAL_NUM_CHANNEL * `CHANNEL_WIDTH;
    localparam int STAT_WIDTH          = 16;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0]   req_idx_t;
    typedef logic [$clog2(MAX_OUTSTANDING_DEF):0] occ_t;
endpackage

`default_nettype wire

// File: rtl/hdc_fusion_scheduler_if.sv
`default_nettype none
// =============================================================================
// Module      : hdc_fusion_scheduler_if
// Description : Requester, pipeline-input and pipeline-result handshakes.
// Revision    : 1.0 - initial release
// =============================================================================

interface hdc_fusion_scheduler_if
    import hdc_sched_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int FEAT_WIDTH = FEAT_WIDTH_DEF
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*FEAT_WIDTH-1:0] req_features;
    logic                          fin_valid;
    logic                          fin_ready;
    logic [FEAT_WIDTH-1:0]         features_top;
    logic                          dout_valid;
    logic                          dout_ready;
    logic                          valence;
    logic                          arousal;
    logic [NUM_REQ-1:0]            res_valid;
    logic [NUM_REQ-1:0]            res_ready;
    logic                          res_valence;
    logic                          res_arousal;
    logic                          tag_err;

    modport master (
        output req_valid, req_features, fin_ready, dout_valid, valence, arousal, res_ready,
        input  req_ready, fin_valid, features_top, dout_ready, res_valid,
               res_valence, res_arousal, tag_err
    );

    modport slave (
        input  req_valid, req_features, fin_ready, dout_valid, valence, arousal, res_ready,
        output req_ready, fin_valid, features_top, dout_ready, res_valid,
               res_valence, res_arousal, tag_err
    );
endinterface

`default_nettype wire

// File: rtl/hdc_tag_fifo.sv
`default_nettype none
// =============================================================================
// Module      : hdc_tag_fifo
// Description : In-order synchronous FIFO of requester indices for issued windows.
// Revision    : 1.0 - initial release
// =============================================================================

module hdc_tag_fifo
    import hdc_sched_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF,
    parameter int WIDTH = $bits(req_idx_t)
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire logic [WIDTH-1:0]       push_data,
    input  wire logic                   pop,
    output logic      [WIDTH-1:0]       head,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
endmodule

`default_nettype wire

// File: rtl/hdc_fusion_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : hdc_fusion_scheduler
// Description : Round-robin sharing of one HDC fusion pipeline between requesters,
//               with in-order tag return. Optional stats: HDC_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// =============================================================================

module hdc_fusion_scheduler
    import hdc_sched_pkg::*;
#(
    parameter int NUM_REQ         = NUM_REQ_DEF,
    parameter int FEAT_WIDTH      = FEAT_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  wire logic                                clk,
    input  wire logic                                rst,
`ifdef HDC_SCHED_STATS_EN
    output logic [NUM_REQ*STAT_WIDTH-1:0]            issue_count,
    output logic [$clog2(MAX_OUTSTANDING):0]         max_occupancy,
`endif
    hdc_fusion_scheduler_if.slave                    bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int OCC_W = $clog2(MAX_OUTSTANDING) + 1;

    logic                  r_fin_valid;
    logic [FEAT_WIDTH-1:0] r_features;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic                  r_tag_err;

    logic [IDX_W-1:0]      w_grant;
    logic                  w_any;
    logic                  w_load;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic [IDX_W-1:0]      w_head;
    logic [OCC_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;

    // Scan from the RR pointer downward so the lowest offset wins last.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_grant = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                w_any   = 1'b1;
            end
        end
    end

    // Full uses the registered count, so a same-cycle pop cannot free a slot.
    assign w_load      = (!r_fin_valid || bus.fin_ready) && w_any && !w_full;
    assign w_req_ready = w_load ? (NUM_REQ'(1) << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fin_valid <= 1'b0;
            r_features  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_fin_valid <= 1'b1;
            r_features  <= bus.req_features[w_grant*FEAT_WIDTH +: FEAT_WIDTH];
            r_rr_ptr    <= (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
        end else if (bus.fin_ready) begin
            r_fin_valid <= 1'b0;
        end
    end

    hdc_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_load),
        .push_data (w_grant),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Results are steered to the FIFO head; a stalled owner blocks the stream.
    assign bus.res_valid   = (!w_empty && bus.dout_valid) ? (NUM_REQ'(1) << w_head) : '0;
    assign bus.dout_ready  = !w_empty && bus.res_ready[w_head];
    assign bus.res_valence = !w_empty && bus.valence;
    assign bus.res_arousal = !w_empty && bus.arousal;
    assign w_pop           = bus.dout_valid && bus.dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_err <= 1'b0;
        end else if (bus.dout_valid && w_empty) begin
            r_tag_err <= 1'b1;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.fin_valid    = r_fin_valid;
    assign bus.features_top = r_features;
    assign bus.tag_err      = r_tag_err;

`ifdef HDC_SCHED_STATS_EN
    logic [OCC_W-1:0] r_max_occ;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [STAT_WIDTH-1:0] r_issue;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_issue <= '0;
            end else if (w_req_ready[gi] && (r_issue != {STAT_WIDTH{1'b1}})) begin
                r_issue <= r_issue + 1'b1;
            end
        end
        assign issue_count[gi*STAT_WIDTH +: STAT_WIDTH] = r_issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_occ <= '0;
        end else if (w_count > r_max_occ) begin
            r_max_occ <= w_count;
        end
    end
    assign max_occupancy = r_max_occ;
`else
    logic w_unused_count;
    assign w_unused_count = ^w_count;
`endif
endmodule

`default_nettype wire

// File: tb/tb_hdc_fusion_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : tb_hdc_fusion_scheduler
// Description : Self-checking bench: vector table, corner sequences, random vs model.
// Revision    : 1.0 - initial release
// =============================================================================

module tb_hdc_fusion_scheduler;
    localparam int NR   = 4;
    localparam int FW   = 32;
    localparam int MAXO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdc_fusion_scheduler_if #(.NUM_REQ(NR), .FEAT_WIDTH(FW)) bus ();

`ifdef HDC_SCHED_STATS_EN
    logic [NR*16-1:0]          issue_count;
    logic [$clog2(MAXO):0]     max_occupancy;
`endif

    hdc_fusion_scheduler #(
        .NUM_REQ         (NR),
        .FEAT_WIDTH      (FW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef HDC_SCHED_STATS_EN
        .issue_count   (issue_count),
        .max_occupancy (max_occupancy),
`endif
        .bus           (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: held window, outstanding owners in issue order.
    bit          m_fv;
    logic [FW-1:0] m_ft;
    int          m_rr;
    int          m_q[$];
    bit          m_terr;

    typedef struct {
        logic [3:0]  rv;
        logic        fr, dv, val, ar;
        logic [3:0]  rdy;
        logic [3:0]  e_rr;
        logic        e_fv;
        logic [31:0] e_ft;
        logic [3:0]  e_res;
        logic        e_dr, e_val, e_ar;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic logic [31:0] feat_of(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic idle_inputs();
        bus.req_valid    = '0;
        bus.req_features = {feat_of(3), feat_of(2), feat_of(1), feat_of(0)};
        bus.fin_ready    = 1'b0;
        bus.dout_valid   = 1'b0;
        bus.valence      = 1'b0;
        bus.arousal      = 1'b0;
        bus.res_ready    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_fv   = 1'b0;
        m_ft   = '0;
        m_rr   = 0;
        m_terr = 1'b0;
        m_q.delete();
    endtask

    // One cycle against the model: inputs already driven at posedge+1.
    task automatic model_cycle(input string nm);
        bit            ld;
        int            g;
        int            idx;
        int            h;
        logic [NR-1:0] e_rq, e_res;
        logic          e_dr, e_val, e_ar;
        logic [FW-1:0] g_data;
        bit            pop, terr_set;
        settle();
        ld = 1'b0; g = 0;
        if ((!m_fv || bus.fin_ready) && m_q.size() < MAXO) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_rr + k) % NR;
                if (!ld && bus.req_valid[idx]) begin
                    ld = 1'b1;
                    g  = idx;
                end
            end
        end
        e_rq   = ld ? NR'(1 << g) : '0;
        g_data = bus.req_features[g*FW +: FW];
        if (m_q.size() > 0) begin
            h     = m_q[0];
            e_res = bus.dout_valid ? NR'(1 << h) : '0;
            e_dr  = bus.res_ready[h];
            e_val = bus.valence;
            e_ar  = bus.arousal;
        end else begin
            e_res = '0; e_dr = 1'b0; e_val = 1'b0; e_ar = 1'b0;
        end
        pop      = bus.dout_valid && e_dr;
        terr_set = bus.dout_valid && (m_q.size() == 0);
        chk({nm, " ctl"},
            64'({bus.req_ready, bus.res_valid, bus.dout_ready, bus.res_valence,
                 bus.res_arousal, bus.fin_valid, bus.tag_err}),
            64'({e_rq, e_res, e_dr, e_val, e_ar, m_fv, m_terr}));
        chk({nm, " data"}, 64'(bus.features_top), 64'(m_ft));
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (terr_set) m_terr = 1'b1;
        if (ld) begin
            m_q.push_back(g);
            m_fv = 1'b1;
            m_ft = g_data;
            m_rr = (g + 1) % NR;
        end else if (bus.fin_ready) begin
            m_fv = 1'b0;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int tally[NR];

        vt[0] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0100, 1'b0, 32'h0,         4'b0000, 1'b0, 1'b0, 1'b0};
        vt[1] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 32'hC0DE_0002, 4'b0100, 1'b1, 1'b1, 1'b0};
        vt[2] = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1000, 1'b0, 32'hC0DE_0002, 4'b0000, 1'b0, 1'b0, 1'b0};
        vt[3] = '{4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 32'hC0DE_0003, 4'b1000, 1'b1, 1'b0, 1'b1};
        vt[4] = '{4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1110, 4'b0000, 1'b1, 32'hC0DE_0000, 4'b0001, 1'b0, 1'b1, 1'b1};
        vt[5] = '{4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0010, 1'b1, 32'hC0DE_0000, 4'b0001, 1'b1, 1'b0, 1'b0};
        vt[6] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'hC0DE_0001, 4'b0000, 1'b0, 1'b0, 1'b0};
        vt[7] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 32'hC0DE_0001, 4'b0010, 1'b1, 1'b1, 1'b0};

        // Reset state
        do_reset();
        settle();
        chk("reset outputs",
            64'({bus.req_ready, bus.res_valid, bus.dout_ready, bus.res_valence,
                 bus.res_arousal, bus.fin_valid, bus.tag_err}), 64'(0));
        chk("reset features", 64'(bus.features_top), 64'(0));
        tick();

        // Vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.req_valid  = vt[i].rv;
            bus.fin_ready  = vt[i].fr;
            bus.dout_valid = vt[i].dv;
            bus.valence    = vt[i].val;
            bus.arousal    = vt[i].ar;
            bus.res_ready  = vt[i].rdy;
            settle();
            chk($sformatf("vec%0d", i),
                64'({bus.req_ready, bus.fin_valid, bus.features_top, bus.res_valid,
                     bus.dout_ready, bus.res_valence, bus.res_arousal}),
                64'({vt[i].e_rr, vt[i].e_fv, vt[i].e_ft, vt[i].e_res,
                     vt[i].e_dr, vt[i].e_val, vt[i].e_ar}));
            tick();
        end

        // Round-robin fairness with prompt results
        do_reset();
        bus.req_valid = 4'b1111; bus.fin_ready = 1'b1; bus.res_ready = 4'b1111;
        for (int k = 0; k < NR; k++) tally[k] = 0;
        for (int k = 0; k < 16; k++) begin
            bus.dout_valid = (k > 0);
            settle();
            chk($sformatf("rr order %0d", k), 64'(bus.req_ready), 64'(1 << (k % NR)));
            for (int j = 0; j < NR; j++) tally[j] += int'(bus.req_ready[j]);
            tick();
        end
        for (int j = 0; j < NR; j++) chk($sformatf("rr share %0d", j), 64'(tally[j]), 64'(4));
        chk("rr tag_err", 64'(bus.tag_err), 64'(0));
`ifdef HDC_SCHED_STATS_EN
        for (int j = 0; j < NR; j++)
            chk($sformatf("issue_count %0d", j), 64'(issue_count[j*16 +: 16]), 64'(4));
`endif

        // Pipeline back-pressure holds the window
        do_reset();
        bus.req_valid = 4'b0001;
        settle();
        chk("stall first grant", 64'(bus.req_ready), 64'(4'b0001));
        tick();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("stall hold %0d", k),
                64'({bus.fin_valid, bus.req_ready, bus.features_top}),
                64'({1'b1, 4'b0000, feat_of(0)}));
            tick();
        end
        bus.fin_ready = 1'b1;
        settle();
        chk("stall release grant", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        bus.fin_ready = 1'b0; bus.req_valid = 4'b0000;
        settle();
        chk("stall next window", 64'({bus.fin_valid, bus.features_top}), 64'({1'b1, feat_of(1)}));
        tick();

        // Outstanding limit, reload one cycle after a pop
        do_reset();
        bus.req_valid = 4'b1111; bus.fin_ready = 1'b1; bus.res_ready = 4'b1111;
        for (int k = 0; k < MAXO; k++) begin
            settle();
            chk($sformatf("fill %0d", k), 64'(bus.req_ready), 64'(1 << (k % NR)));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("full block %0d", k), 64'(bus.req_ready), 64'(0));
            tick();
        end
        bus.dout_valid = 1'b1;
        settle();
        chk("full pop cycle", 64'({bus.req_ready, bus.dout_ready, bus.res_valid}),
            64'({4'b0000, 1'b1, 4'b0001}));
        tick();
        bus.dout_valid = 1'b0;
        settle();
        chk("full reload", 64'(bus.req_ready), 64'(4'b0001));
        tick();
        settle();
        chk("full again", 64'(bus.req_ready), 64'(0));
`ifdef HDC_SCHED_STATS_EN
        chk("max_occupancy", 64'(max_occupancy), 64'(MAXO));
`endif
        tick();

        // In-order return with a stalled owner
        do_reset();
        bus.fin_ready = 1'b1; bus.res_ready = 4'b1111;
        bus.req_valid = 4'b0010;
        settle(); chk("order issue 1", 64'(bus.req_ready), 64'(4'b0010)); tick();
        bus.req_valid = 4'b1000;
        settle(); chk("order issue 3", 64'(bus.req_ready), 64'(4'b1000)); tick();
        bus.req_valid = 4'b0000;
        bus.res_ready = 4'b1101; bus.dout_valid = 1'b1; bus.valence = 1'b1; bus.arousal = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("order stall %0d", k), 64'({bus.res_valid, bus.dout_ready}),
                64'({4'b0010, 1'b0}));
            tick();
        end
        bus.res_ready = 4'b1111;
        settle();
        chk("order result 1", 64'({bus.res_valid, bus.dout_ready, bus.res_valence}),
            64'({4'b0010, 1'b1, 1'b1}));
        tick();
        bus.valence = 1'b0; bus.arousal = 1'b1;
        settle();
        chk("order result 3", 64'({bus.res_valid, bus.dout_ready, bus.res_arousal}),
            64'({4'b1000, 1'b1, 1'b1}));
        tick();
        bus.dout_valid = 1'b0;
        settle();
        chk("order drained", 64'({bus.res_valid, bus.dout_ready, bus.tag_err}), 64'(0));
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            bus.req_valid    = NR'($urandom);
            bus.req_features = {$urandom, $urandom, $urandom, $urandom};
            bus.fin_ready    = ($urandom_range(0, 3) != 0);
            bus.dout_valid   = ($urandom_range(0, 9) < 6) && (m_q.size() > 0 || n > 450);
            bus.valence      = 1'($urandom);
            bus.arousal      = 1'($urandom);
            bus.res_ready    = NR'($urandom | $urandom);
            model_cycle($sformatf("rand%0d", n));
        end

        // Result with nothing outstanding
        do_reset();
        bus.dout_valid = 1'b1; bus.res_ready = 4'b1111;
        settle();
        chk("orphan handshake", 64'({bus.dout_ready, bus.res_valid, bus.tag_err}), 64'(0));
        tick();
        bus.dout_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("tag_err sticky %0d", k), 64'(bus.tag_err), 64'(1));
            tick();
        end
        do_reset();
        settle();
        chk("tag_err cleared", 64'(bus.tag_err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
